fetch_decode_control: RTL and testbench

Control stage directly upstream of the register file. It fetches each instruction over the memory MFA/MFC handshake, holds it in the instruction register and sequences the file's controls. Those controls are the `RSLCT` selects, `IR_CU`, `LOAD`, `LOADPC` and `Pcin`, driven once per instruction through a fixed FETCH/DECODE/EXECUTE/WRITEBACK sequence. Only data-processing and branch instructions are decoded.

---
 rtl/fdc_pkg.sv | 37 +++
 rtl/fetch_decode_control_mfc_timer.sv | 47 ++++
 rtl/fetch_decode_control.sv | 132 +++++++++++++
 tb/tb_fetch_decode_control.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fdc_pkg.sv
// fdc_pkg: shared types and constants for the fetch/decode control stage.
// State encoding, instruction-register field positions and the
// instruction-class decode constants.
package fdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  // Register-number fields inside the instruction word
  localparam int REG_W   = 4;
  localparam int RN_LSB  = 16;
  localparam int RD_LSB  = 12;
  localparam int RS_LSB  = 8;
  localparam int RM_LSB  = 0;
  localparam int OFF_LSB = 0;
  localparam int OFF_W   = 24;

  // The PC is always register 15 in the select bundle
  localparam logic [3:0] PC_REG = 4'd15;

  // Class decode: IR[27:26] for data-processing, IR[27:25] for branch,
  // IR[24:23] for the compare/test group that never writes Rd
  localparam logic [1:0] CLS_DP   = 2'b00;
  localparam logic [2:0] CLS_BR   = 3'b101;
  localparam logic [1:0] OPG_TEST = 2'b10;

  // Word offset of a branch, sign-extended and scaled to bytes
  function automatic logic [31:0] branch_offset(input logic [OFF_W-1:0] off);
    return {{6{off[OFF_W-1]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_decode_control_mfc_timer.sv
// mfc_timer: fetch timeout watchdog. Counts FETCH cycles without MFC and
// raises a sticky error each time the budget is used up; the count then
// restarts so the fetch is retried from the same address.
// Only instantiated when FDC_MFC_TIMEOUT_EN is defined.
module mfc_timer
  import fdc_pkg::*;
#(
  parameter int MAX = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_fetch,
  input  logic i_mfc,
  output logic o_err
);

  localparam int CNT_W = $clog2(MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_expire;

  assign w_expire = i_fetch && !i_mfc && (r_cnt == CNT_W'(MAX - 1));

  // Wait counter: idle at zero outside FETCH, so each FETCH entry starts fresh
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_fetch || i_mfc || w_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/fetch_decode_control.sv
// fetch_decode_control: fetches instructions over MFA/MFC, holds them in IR
// and sequences the register-file controls once per instruction.
// Optional fetch timeout (ERR port, mfc_timer) under FDC_MFC_TIMEOUT_EN.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   IDLE      | after reset; moves to FETCH on the next edge
//   FETCH     | MFA high, ADDR=PCout; IR captured on MFC
//   DECODE    | PC increment: LOADPC with Pcin=PCout+PC_STEP
//   EXECUTE   | selects from IR, no writes
//   WRITEBACK | Rd write for data-processing, PC write for branches
module fetch_decode_control
  import fdc_pkg::*;
#(
  parameter logic [31:0] PC_STEP     = 32'd4,
  parameter int          MFC_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic [31:0] MEM_DATA,
  input  logic        MFC,
  input  logic [31:0] PCout,
  output logic        MFA,
  output logic [31:0] ADDR,
  output logic [31:0] IR,
  output logic [19:0] RSLCT,
  output logic        IR_CU,
  output logic        LOAD,
  output logic        LOADPC,
  output logic [31:0] Pcin
`ifdef FDC_MFC_TIMEOUT_EN
  ,
  output logic        ERR
`endif
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic        w_ir_load;
  logic        w_is_dp;
  logic        w_is_test;
  logic        w_is_br;

  assign w_is_dp   = (r_ir[27:26] == CLS_DP);
  assign w_is_test = (r_ir[24:23] == OPG_TEST);
  assign w_is_br   = (r_ir[27:25] == CLS_BR);

  // State register
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Instruction register, loaded only on the accepting FETCH edge
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      r_ir <= '0;
    end else if (w_ir_load) begin
      r_ir <= MEM_DATA;
    end
  end

  // Next-state and control decode; outputs follow state so reset cuts them off
  always_comb begin
    w_next    = r_state;
    w_ir_load = 1'b0;
    MFA       = 1'b0;
    IR_CU     = 1'b0;
    LOAD      = 1'b0;
    LOADPC    = 1'b0;
    Pcin      = '0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        MFA = 1'b1;
        if (MFC) begin
          w_ir_load = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        LOADPC = 1'b1;
        Pcin   = PCout + PC_STEP;
        w_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        IR_CU  = 1'b1;
        w_next = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        IR_CU  = 1'b1;
        w_next = S_FETCH;
        if (w_is_dp && !w_is_test) begin
          LOAD = 1'b1;
        end else if (w_is_br) begin
          LOADPC = 1'b1;
          Pcin   = PCout + branch_offset(r_ir[OFF_LSB +: OFF_W]);
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign ADDR  = PCout;
  assign IR    = r_ir;
  assign RSLCT = {PC_REG,
                  r_ir[RD_LSB +: REG_W],
                  r_ir[RS_LSB +: REG_W],
                  r_ir[RM_LSB +: REG_W],
                  r_ir[RN_LSB +: REG_W]};

`ifdef FDC_MFC_TIMEOUT_EN
  // Fetch watchdog; a timeout leaves the FSM in FETCH so the request repeats
  mfc_timer #(
    .MAX (MFC_TIMEOUT)
  ) u_mfc_timer (
    .i_clk   (Clk),
    .i_rst   (RESET),
    .i_fetch (r_state == S_FETCH),
    .i_mfc   (MFC),
    .o_err   (ERR)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (MFC_TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_fetch_decode_control.sv
// Bench for fetch_decode_control: driver pushes expected per-instruction
// results into a scoreboard; a monitor pops them when the DUT accepts a
// fetch and checks DECODE/EXECUTE/WRITEBACK outputs.
module tb_fetch_decode_control;

  logic        Clk;
  logic        RESET;
  logic [31:0] MEM_DATA;
  logic        MFC;
  logic [31:0] PCout;
  logic        MFA;
  logic [31:0] ADDR;
  logic [31:0] IR;
  logic [19:0] RSLCT;
  logic        IR_CU;
  logic        LOAD;
  logic        LOADPC;
  logic [31:0] Pcin;
`ifdef FDC_MFC_TIMEOUT_EN
  logic        ERR;
`endif

  fetch_decode_control #(
    .PC_STEP     (32'd4),
    .MFC_TIMEOUT (15)
  ) dut (
    .Clk      (Clk),
    .RESET    (RESET),
    .MEM_DATA (MEM_DATA),
    .MFC      (MFC),
    .PCout    (PCout),
    .MFA      (MFA),
    .ADDR     (ADDR),
    .IR       (IR),
    .RSLCT    (RSLCT),
    .IR_CU    (IR_CU),
    .LOAD     (LOAD),
    .LOADPC   (LOADPC),
    .Pcin     (Pcin)
`ifdef FDC_MFC_TIMEOUT_EN
    ,
    .ERR      (ERR)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [19:0] rslct;
    logic        load;
    logic        loadpc;
    logic [31:0] pcin;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: an accepted fetch is followed by DECODE, EXECUTE, WRITEBACK
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (mon_en && !RESET && MFA && MFC) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          @(negedge Clk);
          chk("dec_ir",     IR, e.ir);
          chk("dec_rslct",  {12'd0, RSLCT}, {12'd0, e.rslct});
          chk("dec_loadpc", {31'd0, LOADPC}, 32'd1);
          chk("dec_pcin",   Pcin, e.pc + 32'd4);
          chk("dec_load",   {31'd0, LOAD}, 32'd0);
          chk("dec_mfa",    {31'd0, MFA}, 32'd0);
          @(negedge Clk);
          chk("exe_load",   {31'd0, LOAD}, 32'd0);
          chk("exe_loadpc", {31'd0, LOADPC}, 32'd0);
          chk("exe_ircu",   {31'd0, IR_CU}, 32'd1);
          @(negedge Clk);
          chk("wb_ir",      IR, e.ir);
          chk("wb_load",    {31'd0, LOAD}, {31'd0, e.load});
          chk("wb_loadpc",  {31'd0, LOADPC}, {31'd0, e.loadpc});
          if (e.loadpc) chk("wb_pcin", Pcin, e.pcin);
          chk("wb_ircu",    {31'd0, IR_CU}, 32'd1);
        end
      end
    end
  end

  // One instruction: wait for FETCH, stall, deliver, then toggle MFC outside FETCH
  task automatic run_instr(input logic [31:0] word, input logic [31:0] pc, input int waits,
                           input logic [19:0] rslct, input logic load, input logic loadpc,
                           input logic [31:0] pcin);
    exp_t e;
    int   t;
    t = 0;
    while (!MFA && t < 10) begin
      @(posedge Clk); #1;
      t++;
    end
    chk("fetch_ready", {31'd0, MFA}, 32'd1);
    PCout    = pc;
    MEM_DATA = word;
    e.ir = word; e.pc = pc; e.rslct = rslct; e.load = load; e.loadpc = loadpc; e.pcin = pcin;
    sb.push_back(e);
    for (int i = 0; i < waits; i++) begin
      MFC = 1'b0;
      @(posedge Clk); #1;
      chk("fetch_hold_mfa", {31'd0, MFA}, 32'd1);
    end
    chk("fetch_addr", ADDR, pc);
    MFC = 1'b1;
    @(posedge Clk); #1;
    MEM_DATA = 32'hDEADBEEF;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    MFC = 1'b0;
    chk("next_fetch_mfa", {31'd0, MFA}, 32'd1);
  endtask

  initial begin
    RESET    = 1'b1;
    MFC      = 1'b0;
    PCout    = 32'd0;
    MEM_DATA = 32'd0;
    repeat (2) @(negedge Clk);
    chk("rst_mfa",    {31'd0, MFA}, 32'd0);
    chk("rst_load",   {31'd0, LOAD}, 32'd0);
    chk("rst_loadpc", {31'd0, LOADPC}, 32'd0);
    chk("rst_ircu",   {31'd0, IR_CU}, 32'd0);
    chk("rst_ir",     IR, 32'd0);
    chk("rst_pcin",   Pcin, 32'd0);
    chk("rst_addr",   ADDR, 32'd0);
    chk("rst_rslct",  {12'd0, RSLCT}, 32'h000F0000);
`ifdef FDC_MFC_TIMEOUT_EN
    chk("rst_err",    {31'd0, ERR}, 32'd0);
`endif
    RESET = 1'b0;
    #1 chk("idle_mfa", {31'd0, MFA}, 32'd0);
    @(posedge Clk); #1;
    chk("post_rst_mfa", {31'd0, MFA}, 32'd1);
    mon_en = 1'b1;

    //        word          pc            waits rslct      ld    ldpc  pcin
    run_instr(32'hE0813002, 32'h00000100, 3, 20'hF3021, 1'b1, 1'b0, 32'h0);          // ADD R3,R1,R2
    run_instr(32'hE1510002, 32'h00000200, 0, 20'hF0021, 1'b0, 1'b0, 32'h0);          // CMP R1,R2
    run_instr(32'hEAFFFFFE, 32'h00000104, 1, 20'hFFFEF, 1'b0, 1'b1, 32'h000000FC);   // B .-8
    run_instr(32'hEA000010, 32'h00001000, 2, 20'hF0000, 1'b0, 1'b1, 32'h00001040);   // B forward
    run_instr(32'hEA7FFFFF, 32'hFFFFFFF0, 0, 20'hFFFFF, 1'b0, 1'b1, 32'h01FFFFEC);   // B with wrap
    run_instr(32'hE5912000, 32'h00000300, 1, 20'hF2001, 1'b0, 1'b0, 32'h0);          // LDR: no loads
    run_instr(32'hE1812003, 32'h00000400, 0, 20'hF2031, 1'b1, 1'b0, 32'h0);          // ORR
    run_instr(32'hE1310002, 32'h00000500, 2, 20'hF0021, 1'b0, 1'b0, 32'h0);          // TEQ
    run_instr(32'hE0A12003, 32'h00000600, 0, 20'hF2031, 1'b1, 1'b0, 32'h0);          // ADC
    mon_en = 1'b0;
    chk("sb_drained", sb.size(), 32'd0);

    // Reset during WRITEBACK cuts the LOAD pulse immediately
    PCout    = 32'h00000700;
    MEM_DATA = 32'hE0813002;
    MFC      = 1'b1;
    @(posedge Clk); #1;
    MFC = 1'b0;
    chk("pre_rst_dec_loadpc", {31'd0, LOADPC}, 32'd1);
    repeat (2) begin
      @(posedge Clk); #1;
    end
    chk("pre_rst_wb_load", {31'd0, LOAD}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("cut_load",   {31'd0, LOAD}, 32'd0);
    chk("cut_loadpc", {31'd0, LOADPC}, 32'd0);
    chk("cut_ircu",   {31'd0, IR_CU}, 32'd0);
    chk("cut_ir",     IR, 32'd0);

    // Reset mid-FETCH drops MFA in the same timestep
    @(negedge Clk);
    RESET = 1'b0;
    @(posedge Clk); #1;
    chk("refetch_mfa", {31'd0, MFA}, 32'd1);
    @(posedge Clk); #2;
    RESET = 1'b1;
    #1 chk("midfetch_rst_mfa", {31'd0, MFA}, 32'd0);

`ifdef FDC_MFC_TIMEOUT_EN
    @(negedge Clk);
    RESET = 1'b0;
    MFC   = 1'b0;
    @(posedge Clk); #1;
    repeat (14) @(posedge Clk);
    #1 chk("tmo_before", {31'd0, ERR}, 32'd0);
    @(posedge Clk); #1;
    chk("tmo_err", {31'd0, ERR}, 32'd1);
    chk("tmo_mfa", {31'd0, MFA}, 32'd1);
    chk("tmo_ir",  IR, 32'd0);
    repeat (3) @(posedge Clk);
    #1 chk("tmo_sticky", {31'd0, ERR}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("tmo_rst_err", {31'd0, ERR}, 32'd0);
    chk("tmo_rst_mfa", {31'd0, MFA}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
